// File: rtl/sd_clk_pkg.sv
// Shared types and constants for the SD-card clock generator.
package sd_clk_pkg;

    localparam int unsigned SD_WIDTH_DEF   = 16;
    localparam int unsigned SD_BURST_W_DEF = 8;
    localparam int unsigned SD_INIT_CLKS   = 74;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } sd_state_e;

endpackage

// File: rtl/sd_half_cnt.sv
// 1-based compare counter: counts 1..limit while running, tc flags the terminal count.
module sd_half_cnt
    import sd_clk_pkg::*;
#(
    parameter int unsigned WIDTH = SD_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             run,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;

    // Combinational on purpose: the parent registers every decision made from tc.
    assign tc = (cnt == limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= WIDTH'(1);
        end else if (load || (run && tc)) begin
            cnt <= WIDTH'(1);
        end else if (run) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sd_clk_div.sv
// Programmable SD clock divider with edge strobes, glitch-free stop and counted bursts.
module sd_clk_div
    import sd_clk_pkg::*;
#(
    parameter int unsigned WIDTH   = SD_WIDTH_DEF,
    parameter int unsigned BURST_W = SD_BURST_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [WIDTH-1:0]   div,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
    output logic               sd_clk,
    output logic               rise_stb,
    output logic               fall_stb,
    output logic               active,
    output logic               burst_done
);

    sd_state_e          state, state_n;
    logic [WIDTH-1:0]   div_l, div_l_n, div_eff;
    logic [BURST_W-1:0] bc, bc_n;
    logic               sd_clk_n, rise_n, fall_n, done_n, active_n;
    logic               hc_load, hc_tc;

    sd_half_cnt #(.WIDTH(WIDTH)) u_hc (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (hc_load),
        .run     (state != ST_IDLE),
        .limit   (div_l),
        .tc      (hc_tc)
    );

    assign div_eff = (div == '0) ? WIDTH'(1) : div;

    // Next-state and next-output decode
    always_comb begin
        state_n  = state;
        sd_clk_n = sd_clk;
        rise_n   = 1'b0;
        fall_n   = 1'b0;
        done_n   = 1'b0;
        div_l_n  = div_l;
        bc_n     = bc;
        hc_load  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (burst_start) begin
                    state_n = ST_BURST;
                    bc_n    = burst_len;
                    hc_load = 1'b1;
                    div_l_n = div_eff;
                end else if (en) begin
                    state_n = ST_RUN;
                    hc_load = 1'b1;
                    div_l_n = div_eff;
                end
            end
            ST_RUN: begin
                if (hc_tc) begin
                    if (sd_clk) begin
                        sd_clk_n = 1'b0;
                        fall_n   = 1'b1;
                        div_l_n  = div_eff;
                        if (!en) state_n = ST_IDLE;
                    end else if (en) begin
                        sd_clk_n = 1'b1;
                        rise_n   = 1'b1;
                    end else begin
                        // Stop while low: the pending rise is simply never issued.
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_BURST: begin
                if (bc == '0) begin
                    // Zero-length burst: complete immediately without any edges.
                    done_n  = 1'b1;
                    state_n = en ? ST_RUN : ST_IDLE;
                    hc_load = 1'b1;
                    div_l_n = div_eff;
                end else if (hc_tc) begin
                    if (sd_clk) begin
                        sd_clk_n = 1'b0;
                        fall_n   = 1'b1;
                        div_l_n  = div_eff;
                        bc_n     = bc - BURST_W'(1);
                        if (bc == BURST_W'(1)) begin
                            done_n  = 1'b1;
                            state_n = en ? ST_RUN : ST_IDLE;
                        end
                    end else begin
                        sd_clk_n = 1'b1;
                        rise_n   = 1'b1;
                    end
                end
            end
            default: begin
                state_n  = ST_IDLE;
                sd_clk_n = 1'b0;
            end
        endcase
        active_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            div_l      <= WIDTH'(1);
            bc         <= '0;
            sd_clk     <= 1'b0;
            rise_stb   <= 1'b0;
            fall_stb   <= 1'b0;
            active     <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_n;
            div_l      <= div_l_n;
            bc         <= bc_n;
            sd_clk     <= sd_clk_n;
            rise_stb   <= rise_n;
            fall_stb   <= fall_n;
            active     <= active_n;
            burst_done <= done_n;
        end
    end

endmodule

// File: doc/sd_clk_div.md
# sd_clk_div

Programmable SD-card clock generator for the host controller. Divides the system clock by a run-time divisor to produce `sd_clk`, with single-cycle rise/fall strobes that the CMD and DAT engines use to launch and sample. It also supports a counted burst of N SD clocks, for example the 74-clock power-up sequence. It is the parametrised successor of the single-compare tick counter: variable width, glitch-free stop, and a burst mode.

## Interface

- `WIDTH`, 16: width of the divisor and the half-period counter.
- `BURST_W`, 8: width of the burst length.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: free-run request (level).
- `div` in WIDTH: half-period of `sd_clk` in `clk` cycles; 0 is treated as 1.
- `burst_start` in 1: one-cycle request to emit `burst_len` SD clocks.
- `burst_len` in BURST_W: number of SD clock periods in a burst.
- `sd_clk` out 1: generated SD clock, registered.
- `rise_stb` out 1: high for the first `clk` cycle of each `sd_clk` high phase.
- `fall_stb` out 1: high for the first `clk` cycle of each `sd_clk` low phase.
- `active` out 1: high whenever state is not IDLE.
- `burst_done` out 1: one-cycle pulse when a burst completes.

## Operation

- States: IDLE, RUN, BURST.
- Registers:
  - `hc`: half-period counter, WIDTH bits, counts 1..`div_l`.
  - `div_l`: latched divisor, always ≥ 1.
  - `bc`: remaining burst periods, BURST_W bits.
- Reset value of every output is 0. Internal reset values: state=IDLE, `hc`=1, `div_l`=1, `bc`=0.
- IDLE: `sd_clk`=0.
  - `burst_start`=1 → BURST with `bc`=`burst_len`.
  - Otherwise `en`=1 → RUN.
  - On either start: `hc`←1, `div_l`←max(`div`,1).
  - `burst_start` and `en` in the same cycle: BURST wins.
- RUN/BURST, terminal count (`hc`==`div_l`) → toggle `sd_clk`, `hc`←1. Otherwise `hc`←`hc`+1.
- Rising toggle → `rise_stb` in the same register update. Falling toggle → `fall_stb`.
- `div_l` reloads from `div` only at a falling toggle. A `div` change mid-period never alters the current period.
- Stop in RUN with `en`=0, evaluated only at terminal count:
  - `sd_clk`=1: fall normally (`fall_stb`=1), then go IDLE.
  - `sd_clk`=0: suppress the rise, no strobe, go IDLE.
  - The high phase is never truncated, so `sd_clk` has no glitches.
- BURST:
  - `bc` decrements at each falling toggle.
  - The fall that takes `bc` to 0 asserts `burst_done` and leaves BURST: to RUN if `en`=1, else IDLE.
  - `en` is ignored for stopping while in BURST.
- `burst_start` outside IDLE is ignored.
- `burst_len`=0: `burst_done` pulses in the cycle after the start, with no `sd_clk` edges. Next state is RUN if `en`, else IDLE.
- Arithmetic:
  - `hc` never exceeds `div_l`, so there is no wrap.
  - Full period = 2·max(`div`,1) `clk` cycles.
  - Maximum period = 2·(2^WIDTH−1).

## Timing

- Start accepted at edge T (IDLE→RUN/BURST): first `sd_clk` rise at edge T+`div_l`.
- `div`=1: `sd_clk` = `clk`/2, with `rise_stb` and `fall_stb` alternating every cycle.
- All outputs are registered; there is no combinational path from input to output.
- `burst_done` coincides with the final `fall_stb`. `active` falls on the same edge when the next state is IDLE.
- Stop latency from `en` deassertion: at most `div_l` cycles if `sd_clk` is low, at most `div_l` cycles if high (completes the current phase).
- `reset_n` asserted mid-operation: all outputs go to 0 immediately and asynchronously; a partial phase is discarded. After release, the block resumes from IDLE on the first `clk` edge.

## Structure

- Package `sd_clk_pkg`:
  - state enum (IDLE, RUN, BURST);
  - default `WIDTH`/`BURST_W` constants;
  - constant for the 74-clock init burst length.
- Sub-module `sd_half_cnt`:
  - WIDTH-parametrised 1-based compare counter with `load`, `run` and a `tc` output;
  - the generalised form of the existing tick counter;
  - instantiated once for `hc`.
- Top level holds the FSM, `div_l`, `bc` and the output registers.

## Test plan

- `div`=1, `en`=1 from reset → first rise 1 cycle after start; period 2; `rise_stb`/`fall_stb` alternate each cycle; 100 periods checked.
- `div`=3 while running; set `div`=5 during a high phase → current period 6 cycles, next period 10 cycles.
- `div`=2, `burst_len`=74, `burst_start` pulse, `en`=0 → exactly 74 `rise_stb` and 74 `fall_stb`; `burst_done` on the 74th fall; `active`=0 and `sd_clk`=0 afterward.
- `div`=4, drop `en` 2 cycles into a high phase → high lasts the full 4 cycles, then fall, then IDLE. Drop `en` during a low phase → no further rise and no strobe.
- `burst_len`=0 → `burst_done` the cycle after start, no edges. `div`=0 with `en` → behaves as `div`=1.
- `reset_n` low mid-high phase with `div`=8 → `sd_clk`, strobes and `active` go to 0 immediately. After release with `en`=1, first rise after 8 cycles.
